// File: rtl/dma_rq_tag_manager.sv
// MRd request issuer and read-tag owner: splits host read commands into single-beat RQ descriptors.
// Optional per-tag timeout is compiled in with `define DMA_RQ_TAG_TIMEOUT_EN.
module dma_rq_tag_manager #(
  parameter int C_BUS_DATA_WIDTH        = 256,
  parameter int C_BUS_KEEP_WIDTH        = C_BUS_DATA_WIDTH / 32,
  parameter int C_WINDOW_SIZE           = 16,
  parameter int C_LOG2_MAX_READ_REQUEST = 9,
  parameter int C_TIMEOUT_CYCLES        = 65535
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic [63:0]                   CMD_ADDR,
  input  logic [31:0]                   CMD_BYTES,
  input  logic [7:0]                    CFG_WINDOW_LIMIT,
  output logic [C_BUS_DATA_WIDTH-1:0]   M_AXIS_RQ_TDATA,
  output logic [59:0]                   M_AXIS_RQ_TUSER,
  output logic [C_BUS_KEEP_WIDTH-1:0]   M_AXIS_RQ_TKEEP,
  output logic                          M_AXIS_RQ_TLAST,
  output logic                          M_AXIS_RQ_TVALID,
  input  logic                          M_AXIS_RQ_TREADY,
  output logic [C_WINDOW_SIZE-1:0]      BUSY_TAGS,
  output logic [C_WINDOW_SIZE*11-1:0]   SIZE_TAGS,
  input  logic [C_WINDOW_SIZE-1:0]      COMPLETED_TAGS,
  output logic [63:0]                   CURRENT_WINDOW_SIZE,
  output logic [63:0]                   WORD_COUNT,
  output logic [C_WINDOW_SIZE-1:0]      ERROR_TAGS,
  output logic                          CMD_DONE
);

  localparam int TAG_W = (C_WINDOW_SIZE > 1) ? $clog2(C_WINDOW_SIZE) : 1;
  localparam logic [12:0] MRRS_BYTES = 13'(1 << C_LOG2_MAX_READ_REQUEST);
  localparam logic [8:0]  WIN_SIZE9  = 9'(C_WINDOW_SIZE);
  localparam logic [C_BUS_KEEP_WIDTH-1:0] KEEP_VALID = C_BUS_KEEP_WIDTH'(8'h0F);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHUNK = 3'd1;
  localparam logic [2:0] ST_ALLOC = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]                  state_r;
  logic [63:0]                 addr_r;
  logic [31:0]                 rem_r;
  logic [12:0]                 len_r;
  logic [C_WINDOW_SIZE-1:0]    busy_r;
  logic [C_WINDOW_SIZE*11-1:0] size_r;
  logic [63:0]                 cws_r;
  logic [63:0]                 word_count_r;
  logic                        cmd_ready_r;
  logic                        cmd_done_r;
  logic                        tvalid_r;
  logic                        tlast_r;
  logic [C_BUS_DATA_WIDTH-1:0] tdata_r;
  logic [59:0]                 tuser_r;
  logic [C_BUS_KEEP_WIDTH-1:0] tkeep_r;

  logic [8:0]                  limit_s;
  logic [C_WINDOW_SIZE-1:0]    free_s;
  logic                        any_free_s;
  logic [TAG_W-1:0]            pick_s;
  logic                        grant_s;
  logic [C_WINDOW_SIZE-1:0]    grant_vec_s;
  logic [C_WINDOW_SIZE-1:0]    timeout_s;
  logic [12:0]                 rem_cap_s;
  logic [12:0]                 bound_s;
  logic [12:0]                 len_s;

  function automatic logic [63:0] popcount(input logic [C_WINDOW_SIZE-1:0] v);
    logic [63:0] n;
    n = 64'd0;
    for (int j = 0; j < C_WINDOW_SIZE; j++) begin
      n = n + 64'(v[j]);
    end
    return n;
  endfunction

  function automatic logic [C_BUS_DATA_WIDTH-1:0] build_desc(input logic [63:0] addr,
                                                             input logic [10:0] dw,
                                                             input logic [TAG_W-1:0] tag);
    logic [C_BUS_DATA_WIDTH-1:0] d;
    d         = '0;
    d[63:0]   = addr;
    d[74:64]  = dw;
    d[78:75]  = 4'b0000;
    d[103:96] = 8'(tag);
    return d;
  endfunction

  // Chunk length: remaining bytes, MRRS and distance to the next 4 KB boundary
  always_comb begin
    rem_cap_s = (rem_r > 32'd4096) ? 13'd4096 : rem_r[12:0];
    bound_s   = 13'd4096 - {1'b0, addr_r[11:0]};
    len_s     = rem_cap_s;
    if (MRRS_BYTES < len_s) begin
      len_s = MRRS_BYTES;
    end else begin
      len_s = len_s;
    end
    if (bound_s < len_s) begin
      len_s = bound_s;
    end else begin
      len_s = len_s;
    end
  end

  // Lowest free tag under the window limit, judged from registered BUSY_TAGS only
  always_comb begin
    limit_s = ((CFG_WINDOW_LIMIT == 8'd0) || ({1'b0, CFG_WINDOW_LIMIT} > WIN_SIZE9)) ?
              WIN_SIZE9 : {1'b0, CFG_WINDOW_LIMIT};
    pick_s  = '0;
    for (int j = 0; j < C_WINDOW_SIZE; j++) begin
      free_s[j] = ~busy_r[j] & (9'(j) < limit_s);
    end
    for (int j = C_WINDOW_SIZE - 1; j >= 0; j--) begin
      pick_s = free_s[j] ? TAG_W'(j) : pick_s;
    end
    any_free_s  = |free_s;
    grant_s     = (state_r == ST_ALLOC) && any_free_s;
    grant_vec_s = grant_s ? (C_WINDOW_SIZE'(1) << pick_s) : '0;
  end

  // Command sequencing and RQ descriptor registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r      <= ST_IDLE;
      addr_r       <= 64'd0;
      rem_r        <= 32'd0;
      len_r        <= 13'd0;
      word_count_r <= 64'd0;
      cmd_ready_r  <= 1'b0;
      cmd_done_r   <= 1'b0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tdata_r      <= '0;
      tuser_r      <= 60'd0;
      tkeep_r      <= '0;
    end else begin
      cmd_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (CMD_VALID && cmd_ready_r) begin
            addr_r       <= CMD_ADDR;
            rem_r        <= CMD_BYTES;
            word_count_r <= 64'd0;
            cmd_ready_r  <= 1'b0;
            state_r      <= ST_CHUNK;
          end else begin
            cmd_ready_r  <= 1'b1;
          end
        end
        ST_CHUNK: begin
          len_r   <= len_s;
          state_r <= ST_ALLOC;
        end
        ST_ALLOC: begin
          if (any_free_s) begin
            tdata_r  <= build_desc(addr_r, len_r[12:2], pick_s);
            tuser_r  <= {52'd0, (len_r == 13'd4) ? 4'h0 : 4'hF, 4'hF};
            tkeep_r  <= KEEP_VALID;
            tlast_r  <= 1'b1;
            tvalid_r <= 1'b1;
            state_r  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (M_AXIS_RQ_TREADY) begin
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            tkeep_r      <= '0;
            addr_r       <= addr_r + 64'(len_r);
            rem_r        <= rem_r - 32'(len_r);
            word_count_r <= word_count_r + 64'(len_r[12:2]);
            state_r      <= (rem_r == 32'(len_r)) ? ST_DRAIN : ST_CHUNK;
          end
        end
        ST_DRAIN: begin
          if (busy_r == '0) begin
            cmd_done_r  <= 1'b1;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag ownership: grant sets, completion or timeout clears; sizes are kept after release
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      busy_r <= '0;
      size_r <= '0;
      cws_r  <= 64'd0;
    end else begin
      busy_r <= (busy_r & ~COMPLETED_TAGS & ~timeout_s) | grant_vec_s;
      for (int j = 0; j < C_WINDOW_SIZE; j++) begin
        if (grant_vec_s[j]) begin
          size_r[11*j +: 11] <= len_r[12:2];
        end
      end
      cws_r <= popcount(busy_r);
    end
  end

`ifdef DMA_RQ_TAG_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);

  logic [15:0]              tmo_cnt_r [C_WINDOW_SIZE];
  logic [C_WINDOW_SIZE-1:0] error_r;

  // A tag expires on the cycle its counter has seen C_TIMEOUT_CYCLES busy cycles
  always_comb begin
    timeout_s = '0;
    for (int j = 0; j < C_WINDOW_SIZE; j++) begin
      timeout_s[j] = busy_r[j] & (tmo_cnt_r[j] == TMO_LAST);
    end
  end

  // Per-tag age counters and sticky timeout flags
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int j = 0; j < C_WINDOW_SIZE; j++) begin
        tmo_cnt_r[j] <= 16'd0;
      end
      error_r <= '0;
    end else begin
      for (int j = 0; j < C_WINDOW_SIZE; j++) begin
        if (grant_vec_s[j]) begin
          tmo_cnt_r[j] <= 16'd0;
        end else if (busy_r[j]) begin
          tmo_cnt_r[j] <= tmo_cnt_r[j] + 16'd1;
          if (timeout_s[j]) begin
            error_r[j] <= 1'b1;
          end
        end
      end
    end
  end

  assign ERROR_TAGS = error_r;
`else
  assign timeout_s  = '0;
  assign ERROR_TAGS = '0;
`endif

  assign CMD_READY           = cmd_ready_r;
  assign CMD_DONE            = cmd_done_r;
  assign M_AXIS_RQ_TDATA     = tdata_r;
  assign M_AXIS_RQ_TUSER     = tuser_r;
  assign M_AXIS_RQ_TKEEP     = tkeep_r;
  assign M_AXIS_RQ_TLAST     = tlast_r;
  assign M_AXIS_RQ_TVALID    = tvalid_r;
  assign BUSY_TAGS           = busy_r;
  assign SIZE_TAGS           = size_r;
  assign CURRENT_WINDOW_SIZE = cws_r;
  assign WORD_COUNT          = word_count_r;

endmodule

// File: tb/tb_dma_rq_tag_manager.sv
// Bench for dma_rq_tag_manager: directed scenarios plus random commands against a
// queue-based model of chunking and lowest-free tag allocation.
module tb_dma_rq_tag_manager;
  localparam int DW   = 256;
  localparam int KW   = 8;
  localparam int WS   = 16;
  localparam int MRRS = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, cmd_valid, cmd_ready, cmd_done;
  logic [63:0]      cmd_addr, cws, wc;
  logic [31:0]      cmd_bytes;
  logic [7:0]       cfg_limit;
  logic [DW-1:0]    tdata;
  logic [59:0]      tuser;
  logic [KW-1:0]    tkeep;
  logic             tlast, tvalid, tready;
  logic [WS-1:0]    busy, completed, err;
  logic [WS*11-1:0] size_tags;

  dma_rq_tag_manager #(
    .C_BUS_DATA_WIDTH(DW), .C_BUS_KEEP_WIDTH(KW), .C_WINDOW_SIZE(WS),
    .C_LOG2_MAX_READ_REQUEST(9), .C_TIMEOUT_CYCLES(100)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_ADDR(cmd_addr), .CMD_BYTES(cmd_bytes), .CFG_WINDOW_LIMIT(cfg_limit),
    .M_AXIS_RQ_TDATA(tdata), .M_AXIS_RQ_TUSER(tuser), .M_AXIS_RQ_TKEEP(tkeep),
    .M_AXIS_RQ_TLAST(tlast), .M_AXIS_RQ_TVALID(tvalid), .M_AXIS_RQ_TREADY(tready),
    .BUSY_TAGS(busy), .SIZE_TAGS(size_tags), .COMPLETED_TAGS(completed),
    .CURRENT_WINDOW_SIZE(cws), .WORD_COUNT(wc), .ERROR_TAGS(err), .CMD_DONE(cmd_done)
  );

  typedef struct { logic [63:0] addr; logic [10:0] dw; } tlp_t;
  tlp_t        exp_q[$];
  logic [WS-1:0] m_cur, m_prev;
  logic [63:0] exp_wc;
  int          lim_m, done_cnt, total, bad;
  bit          tlp_active, accepted, auto_cpl, rand_ready, chk_en;

  task automatic check_val(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] desc(input logic [63:0] a, input logic [10:0] dw, input int tag);
    logic [DW-1:0] d;
    d = '0;
    d[63:0]   = a;
    d[74:64]  = dw;
    d[103:96] = 8'(tag);
    return d;
  endfunction

  function automatic int pick_tag(input logic [WS-1:0] b, input int lim);
    for (int j = 0; j < lim; j++) if (!b[j]) return j;
    return -1;
  endfunction

  // one clock: apply the edge to the model, check at the falling edge, then drive inputs
  task automatic step();
    bit hs, acc;
    int t;
    hs  = (tvalid === 1'b1) && (tready === 1'b1);
    acc = cmd_valid && (cmd_ready === 1'b1);
    @(posedge clk);
    m_prev = m_cur;
    m_cur  = m_cur & ~completed;
    if (hs) begin
      check_val("tlp_in_queue", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_wc += 64'(exp_q[0].dw);
        void'(exp_q.pop_front());
      end
      tlp_active = 0;
    end
    @(negedge clk);
    if (acc) begin
      cmd_valid = 1'b0;
      accepted  = 1;
      exp_wc    = 64'd0;
    end
    if (tvalid === 1'b1 && !tlp_active) begin
      tlp_active = 1;
      t = pick_tag(m_prev, lim_m);
      check_val("tag_free", t >= 0, 1);
      check_val("tlp_expected", exp_q.size() > 0, 1);
      if (t >= 0 && exp_q.size() > 0) begin
        m_cur[t] = 1'b1;
        check_val("tdata", tdata, desc(exp_q[0].addr, exp_q[0].dw, t));
        check_val("tuser", tuser, (exp_q[0].dw == 11'd1) ? 60'h0F : 60'hFF);
        check_val("tkeep_tlast", {tkeep, tlast}, {8'h0F, 1'b1});
        check_val("size_tags", size_tags[t*11 +: 11], exp_q[0].dw);
      end
    end
    if (chk_en) begin
      check_val("busy", busy, m_cur);
      check_val("cws", cws, $countones(m_prev));
    end
    if (cmd_done === 1'b1) begin
      done_cnt++;
      if (chk_en) begin
        check_val("done_queue", exp_q.size(), 0);
        check_val("done_busy", m_prev, 0);
        check_val("word_count", wc, exp_wc);
        check_val("error_tags", err, 0);
      end
    end
    completed = '0;
    if (auto_cpl) begin
      for (int j = 0; j < WS; j++) begin
        if (m_cur[j]) completed[j] = ($urandom_range(0, 3) == 0);
        else          completed[j] = ($urandom_range(0, 15) == 0);
      end
    end
    if (rand_ready) tready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic issue(input logic [63:0] a, input logic [31:0] n, input logic [7:0] lim);
    logic [63:0] ca;
    longint r, l, b;
    int k;
    cfg_limit = lim;
    lim_m = (lim == 8'd0 || lim > 8'd16) ? WS : int'(lim);
    ca = a;
    r  = longint'(n);
    while (r > 0) begin
      b = 4096 - longint'(ca % 64'd4096);
      l = r;
      if (l > MRRS) l = MRRS;
      if (l > b) l = b;
      exp_q.push_back('{ca, 11'(l / 4)});
      ca += 64'(l);
      r  -= l;
    end
    cmd_addr = a; cmd_bytes = n; cmd_valid = 1'b1; accepted = 0;
    k = 0;
    while (!accepted && k < 50) begin step(); k++; end
    cmd_valid = 1'b0;
    check_val("cmd_accept", accepted, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin step(); k++; end
    check_val("cmd_done_seen", done_cnt - d0, 1);
  endtask

  task automatic wait_tvalid(input int budget);
    int k;
    k = 0;
    while (tvalid !== 1'b1 && k < budget) begin step(); k++; end
    check_val("tvalid_wait", tvalid, 1);
  endtask

  initial begin
    logic [63:0] a;
    logic [DW-1:0] e;
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_bytes = '0; cfg_limit = '0;
    tready = 1'b1; completed = '0; auto_cpl = 0; rand_ready = 0; chk_en = 1;
    m_cur = '0; m_prev = '0; lim_m = WS; exp_wc = '0; total = 0; bad = 0; done_cnt = 0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", cmd_ready, 0);
    check_val("rst_outs", {tvalid, tlast, tkeep, busy, cws, wc, err, cmd_done}, 0);
    check_val("rst_data", {tdata, tuser, size_tags}, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("ready_after_rst", cmd_ready, 1);

    // single TLP, latency, explicit release
    issue(64'h1000, 32'd256, 8'd0);
    n = 1;
    while (tvalid !== 1'b1 && n < 20) begin step(); n++; end
    check_val("latency", n, 3);
    repeat (5) step();
    check_val("t1_no_done", done_cnt, 0);
    check_val("t1_busy", busy, 16'h0001);
    check_val("t1_size", size_tags[10:0], 11'd64);
    completed = 16'h0001;
    wait_done(20);
    check_val("t1_wc", wc, 64'd64);

    // 4 KB split
    issue(64'h0F80, 32'd1024, 8'd0);
    n = 0;
    while (exp_q.size() > 0 && n < 60) begin step(); n++; end
    step();
    check_val("t2_busy", busy, 16'h0007);
    check_val("t2_sizes", size_tags[32:0], {11'd96, 11'd128, 11'd32});
    check_val("t2_wc", wc, 64'd256);
    completed = 16'h0007;
    wait_done(20);

    // window limit stall, then reuse of the released tag
    issue(64'h0, 32'd2048, 8'd2);
    repeat (15) step();
    check_val("t3_stall_tvalid", tvalid, 0);
    check_val("t3_busy", busy, 16'h0003);
    check_val("t3_left", exp_q.size(), 2);
    completed = 16'h0001;
    step();
    wait_tvalid(10);
    check_val("t3_reuse_tag", tdata[103:96], 8'd0);
    auto_cpl = 1;
    wait_done(300);
    auto_cpl = 0;

    // single-DWORD TLP held by backpressure
    tready = 1'b0;
    issue(64'h2004, 32'd4, 8'd0);
    wait_tvalid(10);
    e = desc(64'h2004, 11'd1, 0);
    for (int i = 0; i < 10; i++) begin
      check_val("t4_tdata_stable", tdata, e);
      check_val("t4_tuser_stable", tuser, 60'h0F);
      step();
    end
    tready = 1'b1; auto_cpl = 1;
    wait_done(50);
    auto_cpl = 0;

    // reset while the third TLP waits in SEND
    tready = 1'b0;
    issue(64'h0, 32'd2048, 8'd0);
    for (int h = 0; h < 2; h++) begin
      wait_tvalid(10);
      tready = 1'b1; step(); tready = 1'b0;
    end
    wait_tvalid(10);
    check_val("t5_busy3", busy, 16'h0007);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check_val("t5_busy_rst", busy, 16'h0000);
    check_val("t5_tvalid_rst", tvalid, 0);
    check_val("t5_ready_rst", cmd_ready, 0);
    rst_n = 1'b1; completed = 16'h0002;
    @(posedge clk); @(negedge clk);
    completed = '0;
    check_val("t5_ready", cmd_ready, 1);
    check_val("t5_late_cpl", busy, 16'h0000);
    check_val("t5_wc", wc, 64'd0);
    m_cur = '0; m_prev = '0; exp_q.delete(); tlp_active = 0; tready = 1'b1;

    // random commands
    auto_cpl = 1; rand_ready = 1;
    for (int c = 0; c < 30; c++) begin
      a = {$urandom, $urandom};
      a[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 40));
      issue(a, 32'(4 * $urandom_range(1, 700)), 8'($urandom_range(0, 20)));
      wait_done(4000);
    end
    auto_cpl = 0; rand_ready = 0; tready = 1'b1;

`ifdef DMA_RQ_TAG_TIMEOUT_EN
    chk_en = 0;
    issue(64'h3000, 32'd4, 8'd0);
    wait_tvalid(10);
    n = 0;
    while (busy[0] !== 1'b0 && n < 300) begin step(); n++; end
    check_val("t6_timeout_cycle", n, 100);
    check_val("t6_error", err[0], 1);
    wait_done(20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
